// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {HUNT, CAPTURE} tdm_state_t;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  // Next slot number with natural wrap 3 -> 0.
  function automatic slot_t slot_next(slot_t s);
    return 2'(s + 2'd1);
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-link side and parallel-lane side of the TDM demultiplexer.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
);

  logic             en;
  logic             sync;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             valid;
  logic             locked;
  logic             sync_err;
  logic             sel1;
  logic             sel0;

  // Link driver / lane consumer view.
  modport master (
    output en, sync, din,
    input  out0, out1, out2, out3, valid, locked, sync_err, sel1, sel0
  );

  // Demultiplexer view.
  modport slave (
    input  en, sync, din,
    output out0, out1, out2, out3, valid, locked, sync_err, sel1, sel0
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter: clear beats load-to-1 beats increment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  load1_i,
  input  logic  inc_i,
  output slot_t slot_o,
  output logic  sel1_o,
  output logic  sel0_o
);

  slot_t slot_q;
  slot_t slot_d;

  // Next slot value from the control strobes.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = 2'd0;
    end else if (load1_i) begin
      slot_d = 2'd1;
    end else if (inc_i) begin
      slot_d = slot_next(slot_q);
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= 2'd0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign sel1_o = slot_q[1];
  assign sel0_o = slot_q[0];

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: aligns to frame sync, shadows slots 0..2 and
// publishes the full frame on the slot-3 sample.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  tdm_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NUM_SLOTS-1];
  logic [WIDTH-1:0] shadow_d [NUM_SLOTS-1];
  logic [WIDTH-1:0] out_q    [NUM_SLOTS];
  logic [WIDTH-1:0] out_d    [NUM_SLOTS];
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;

  slot_t            slot;
  logic             ctr_clr;
  logic             ctr_load1;
  logic             ctr_inc;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .inc_i   (ctr_inc),
    .slot_o  (slot),
    .sel1_o  (bus.sel1),
    .sel0_o  (bus.sel0)
  );

  // Alignment FSM, lane capture and frame publish.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    locked_d   = locked_q;
    ctr_clr    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_inc    = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            ctr_load1   = 1'b1;
            state_d     = CAPTURE;
          end else begin
            ctr_clr = 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and
            // restarts alignment on this sample.
            if (slot != 2'd0) begin
              sync_err_d = 1'b1;
              locked_d   = 1'b0;
            end
            shadow_d[0] = bus.din;
            ctr_load1   = 1'b1;
          end else if (slot == 2'd0) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            ctr_clr    = 1'b1;
            state_d    = HUNT;
          end else if (slot == 2'd3) begin
            out_d[0] = shadow_q[0];
            out_d[1] = shadow_q[1];
            out_d[2] = shadow_q[2];
            out_d[3] = bus.din;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            ctr_inc  = 1'b1;
          end else begin
            if (slot == 2'd1) begin
              shadow_d[1] = bus.din;
            end else begin
              shadow_d[2] = bus.din;
            end
            ctr_inc = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          ctr_clr = 1'b1;
        end
      endcase
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      shadow_q   <= shadow_d;
      out_q      <= out_d;
    end
  end

  assign bus.out0     = out_q[0];
  assign bus.out1     = out_q[1];
  assign bus.out2     = out_q[2];
  assign bus.out3     = out_q[3];
  assign bus.valid    = valid_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [4*W-1:0] word_w;
  logic [1:0]     sel_w;
  assign word_w = {bus.out0, bus.out1, bus.out2, bus.out3};
  assign sel_w  = {bus.sel1, bus.sel0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic [W-1:0] d);
    bus.en   = e;
    bus.sync = s;
    bus.din  = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'hF);
    drive(1'b1, 1'b1, 4'hF);
    checks++; if (word_w !== 16'h0) begin failures++; $display("FAIL rst_word got %h want 0000", word_w); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rst_locked got %b want 0", bus.locked); end
    checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL rst_sync_err got %b want 0", bus.sync_err); end
    checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL rst_sel got %0d want 0", sel_w); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] d [4] = '{4'h1, 4'h0, 4'h1, 4'h1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, d[i]);
      checks++; if (sel_w !== 2'(i + 1)) begin failures++; $display("FAIL f1_sel[%0d] got %0d want %0d", i, sel_w, 2'(i + 1)); end
      checks++; if (bus.valid !== (i == 3)) begin failures++; $display("FAIL f1_valid[%0d] got %b want %b", i, bus.valid, i == 3); end
      if (i == 2) begin
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL f1_prelock got %b want 0", bus.locked); end
      end
    end
    checks++; if (word_w !== 16'h1011) begin failures++; $display("FAIL f1_word got %h want 1011", word_w); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL f1_locked got %b want 1", bus.locked); end
    drive(1'b0, 1'b0, 4'h0);
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL f1_valid_drop got %b want 0", bus.valid); end
    checks++; if (word_w !== 16'h1011) begin failures++; $display("FAIL f1_hold got %h want 1011", word_w); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [8] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 4) == 0, d[i]);
      checks++; if (bus.valid !== ((i % 4) == 3)) begin failures++; $display("FAIL b2b_valid[%0d] got %b want %b", i, bus.valid, (i % 4) == 3); end
      checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL b2b_sync_err[%0d] got %b want 0", i, bus.sync_err); end
      if (i == 3) begin
        checks++; if (word_w !== 16'h1100) begin failures++; $display("FAIL b2b_word1 got %h want 1100", word_w); end
      end
      if (i == 7) begin
        checks++; if (word_w !== 16'h0101) begin failures++; $display("FAIL b2b_word2 got %h want 0101", word_w); end
      end
    end
  endtask

  task automatic test_en_gap();
    logic [W-1:0] d [4] = '{4'h1, 4'h0, 4'h1, 4'h1};
    for (int k = 0; k < 8; k++) begin
      if ((k % 2) == 0) drive(1'b1, k == 0, d[k / 2]);
      else              drive(1'b0, 1'b1, 4'hF);
      checks++; if (sel_w !== 2'((k / 2) + 1)) begin failures++; $display("FAIL gap_sel[%0d] got %0d want %0d", k, sel_w, 2'((k / 2) + 1)); end
      checks++; if (bus.valid !== (k == 6)) begin failures++; $display("FAIL gap_valid[%0d] got %b want %b", k, bus.valid, k == 6); end
      if (k == 5) begin
        checks++; if (word_w !== 16'h0101) begin failures++; $display("FAIL gap_hold got %h want 0101", word_w); end
      end
    end
    checks++; if (word_w !== 16'h1011) begin failures++; $display("FAIL gap_word got %h want 1011", word_w); end
  endtask

  task automatic test_early_sync();
    drive(1'b1, 1'b1, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b1, 4'h7);
    checks++; if (bus.sync_err !== 1'b1) begin failures++; $display("FAIL es_err got %b want 1", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL es_locked got %b want 0", bus.locked); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL es_valid got %b want 0", bus.valid); end
    checks++; if (sel_w !== 2'd1) begin failures++; $display("FAIL es_sel got %0d want 1", sel_w); end
    checks++; if (word_w !== 16'h1011) begin failures++; $display("FAIL es_word got %h want 1011", word_w); end
    drive(1'b1, 1'b0, 4'h8);
    checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL es_err_pulse got %b want 0", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL es_locked_hold got %b want 0", bus.locked); end
    checks++; if (sel_w !== 2'd2) begin failures++; $display("FAIL es_sel2 got %0d want 2", sel_w); end
    drive(1'b1, 1'b0, 4'h9);
    drive(1'b1, 1'b0, 4'hA);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL es_valid2 got %b want 1", bus.valid); end
    checks++; if (word_w !== 16'h789A) begin failures++; $display("FAIL es_word2 got %h want 789a", word_w); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL es_relock got %b want 1", bus.locked); end
  endtask

  task automatic test_missing_sync();
    drive(1'b1, 1'b0, 4'h5);
    checks++; if (bus.sync_err !== 1'b1) begin failures++; $display("FAIL ms_err got %b want 1", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL ms_locked got %b want 0", bus.locked); end
    checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL ms_sel got %0d want 0", sel_w); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL ms_valid got %b want 0", bus.valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h6);
      checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL ms_hunt_sel[%0d] got %0d want 0", i, sel_w); end
      checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL ms_hunt_err[%0d] got %b want 0", i, bus.sync_err); end
    end
    drive(1'b0, 1'b1, 4'h1);
    checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL ms_en0_sel got %0d want 0", sel_w); end
    drive(1'b1, 1'b1, 4'h1);
    checks++; if (sel_w !== 2'd1) begin failures++; $display("FAIL ms_resync_sel got %0d want 1", sel_w); end
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b0, 4'h4);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL ms_valid2 got %b want 1", bus.valid); end
    checks++; if (word_w !== 16'h1234) begin failures++; $display("FAIL ms_word got %h want 1234", word_w); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL ms_relock got %b want 1", bus.locked); end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 1'b1, 4'hC);
    drive(1'b1, 1'b0, 4'hD);
    drive(1'b1, 1'b0, 4'hE);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'hF);
    checks++; if (word_w !== 16'h0) begin failures++; $display("FAIL mr_word got %h want 0000", word_w); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL mr_valid got %b want 0", bus.valid); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL mr_locked got %b want 0", bus.locked); end
    checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL mr_sel got %0d want 0", sel_w); end
    checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL mr_err got %b want 0", bus.sync_err); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'hF);
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL mr_post_valid[%0d] got %b want 0", i, bus.valid); end
      checks++; if (sel_w !== 2'd0) begin failures++; $display("FAIL mr_post_sel[%0d] got %0d want 0", i, sel_w); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_gap();
    test_early_sync();
    test_missing_sync();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of a 4:1 multiplexed serial link in which a transmitter steps its 2-bit select through slots 0..3 and marks slot 0 with a frame-sync strobe. The block aligns to the sync, steps its own slot counter, collects one `WIDTH`-bit sample per slot, and presents all four lanes as a registered parallel word with a one-cycle `valid` pulse. It sits between the serial link and any downstream per-lane consumer.

## Interface
- `WIDTH`, default 1: bits per slot sample.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: sample strobe; `sync` and `din` are sampled, and the slot advances, only on cycles with `en`=1.
- `sync` input 1: frame-sync strobe; when high with `en`, the current `din` belongs to slot 0.
- `din` input `WIDTH`: serial sample for the current slot.
- `out0`..`out3` output `WIDTH` each: last complete frame, lanes 0..3.
- `valid` output 1: one-cycle pulse when `out0`..`out3` update.
- `locked` output 1: high while aligned and at least one full frame has been delivered.
- `sync_err` output 1: one-cycle pulse on an alignment violation.
- `sel1`, `sel0` output 1 each: slot number expected on the next `en` cycle (MSB, LSB).

## Operation
- States: HUNT, CAPTURE.
- Reset: state=HUNT, slot=0, `out0`..`out3`=0, shadow lanes 0..2=0, `valid`=0, `locked`=0, `sync_err`=0, `sel1`/`sel0`=0.
- HUNT, `en`&`sync`: shadow0<=`din`, slot<=1, go to CAPTURE.
- HUNT, `en`&!`sync`: `din` discarded; stay in HUNT with slot=0 and no error.
- CAPTURE, `en`, slot 1 or 2, `sync`=0: shadow[slot]<=`din`, slot<=slot+1.
- CAPTURE, `en`, slot 3, `sync`=0: `out0`..`out2`<=shadow0..2, `out3`<=`din`, `valid`<=1, `locked`<=1, slot<=0 (wrap).
- CAPTURE, `en`, slot 0, `sync`=1: normal frame start; shadow0<=`din`, slot<=1.
- CAPTURE, `en`, slot 0, `sync`=0 (missing sync): `sync_err`<=1, `locked`<=0, slot<=0, go to HUNT. `din` is discarded.
- CAPTURE, `en`, slot 1..3, `sync`=1 (early sync): `sync_err`<=1, `locked`<=0. The partial frame is discarded and `out*` are not updated. Treat the cycle as slot 0: shadow0<=`din`, slot<=1, stay in CAPTURE.
- `en`=0: no state, slot, or shadow change. `valid` and `sync_err` are 0.
- `out*` hold their value between `valid` pulses. `locked`, once cleared, stays low until the next complete frame.
- {`sel1`,`sel0`} = slot at all times.

## Timing
- Outputs and `valid` are registered. They update on the same edge that samples slot 3, so `valid` is high for exactly the following cycle.
- Latency from sampling slot 0 to `valid` is 4 `en` cycles (4 clocks with `en` tied high).
- `sync_err` is high for the cycle after the offending sample edge.
- Back-to-back frames with `en`=1 give one `valid` pulse every 4 clocks. No bubble at wrap.
- `rst` dominates all other inputs. Asserting it mid-frame drops the partial frame, and the next cycle shows reset values.

## Structure
- Package `tdm_pkg` holds:
  - `typedef enum logic {HUNT, CAPTURE} tdm_state_t`
  - `localparam int NUM_SLOTS = 4`
  - `typedef logic [1:0] slot_t`
- Sub-module `tdm_slot_ctr` is a 2-bit wrapping counter with synchronous clear, load-to-1, and increment-on-enable; it drives `sel1`/`sel0`.
- Shadow registers and the FSM live in `tdm_demux4`.

## Test plan
- Reset, then `en`=1. Send `sync`=1 with `din`=1, then 0, 1, 1. Required: one `valid` pulse; `out0..3`=1,0,1,1; `locked`=1; `sel` sequence 1,2,3,0.
- Two back-to-back frames 1,1,0,0 and 0,1,0,1 with `en` high. Required: `valid` exactly 4 clocks apart, second word 0,1,0,1, no `sync_err`.
- Drive `en`=1 only every other clock during a frame. Required: same output word; `valid` 7 clocks after slot 0; `sel` holds during the `en`=0 cycles.
- Locked link, then `sync`=1 at slot 2. Required: `sync_err` pulse; `locked`=0; no `valid`; `out*` retain the prior frame; the next complete frame restores `locked`=1.
- Locked link, then `sync`=0 at slot 0. Required: `sync_err` pulse; return to HUNT; `sel`=0 held until the next `sync`.
- Assert `rst` after slot 2 of a frame. Required: all outputs 0 the next cycle; `valid` never pulses for the partial frame.
